timeout_timer: RTL and testbench
================================

# timeout_timer

Programmable down-counting timer that is the counterpart of the timer control logic. It receives Timer_Enable from the controller, counts a configured number of prescaled ticks, and returns Timer_TimeOut, which the controller uses to withdraw Timer_Enable. The timeout period is loaded through a simple configuration port while the timer is idle.

## Interface
- CLK_DIV, default 4: clock cycles per timer tick; legal range is 1 or greater.
- CNT_WIDTH, default 8: width of the period register and the tick counter.
- DEFAULT_TIMEOUT, default 10: period in ticks after reset; legal range is 1 to 2^CNT_WIDTH-1.
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Timer_Enable  in  1  run request from the timer controller.
- Load_Enable  in  1  period load strobe.
- Load_Value  in  CNT_WIDTH  new period, in ticks.
- Timer_TimeOut  out  1  registered; high while in TIMEOUT.
- Timer_Count  out  CNT_WIDTH  registered; remaining ticks, 0 when not running.
- Timer_Busy  out  1  registered; high while in RUN.

## Operation
- Internal state: Period_Reg (CNT_WIDTH bits), prescaler counter (0 to CLK_DIV-1), tick counter (drives Timer_Count), and FSM states IDLE, RUN and TIMEOUT.
- Reset values:
  - state = IDLE, Period_Reg = DEFAULT_TIMEOUT, prescaler = 0.
  - Timer_Count = 0, Timer_TimeOut = 0, Timer_Busy = 0.
- Load:
  - In IDLE with Load_Enable=1: Period_Reg <= Load_Value.
  - Load_Value = 0 is clamped to 1.
  - Load_Enable is ignored in RUN and TIMEOUT; Period_Reg is unchanged.
- IDLE:
  - Timer_Enable=1 moves the FSM to RUN, sets prescaler <= 0, and sets Timer_Count <= period.
  - If Load_Enable is also 1 in the same cycle, the loaded (clamped) value is the period used for this run.
- RUN:
  - A tick occurs in any cycle where prescaler = CLK_DIV-1; the prescaler then wraps to 0, otherwise it increments.
  - On a tick, Timer_Count decrements.
  - A tick with Timer_Count = 1 sets Timer_Count to 0 and moves the FSM to TIMEOUT.
  - Timer_Enable=0 in RUN moves the FSM to IDLE, clears Timer_Count and the prescaler, and does not assert a timeout. This check has priority over a tick in the same cycle.
- TIMEOUT:
  - Timer_TimeOut is held at 1 while Timer_Enable=1.
  - Timer_Enable=0 moves the FSM to IDLE and clears Timer_TimeOut.
  - A new run requires a pass through IDLE.
- Arithmetic: the counter never wraps below 0. Widths are unsigned CNT_WIDTH; the prescaler is sized for CLK_DIV-1, with a minimum width of 1.

## Timing
- Let E be the edge that samples Timer_Enable=1 in IDLE with period P.
  - Timer_Busy goes to 1 after edge E.
  - Timer_TimeOut goes to 1, and Timer_Busy to 0, after edge E + P*CLK_DIV.
- With CLK_DIV = 1, every RUN cycle is a tick.
- Timer_TimeOut deasserts one edge after Timer_Enable is sampled low.
- Closed loop with the controller (Timer_Enable = Config_Enable AND NOT Timer_TimeOut), with Config_Enable held high:
  - Timer_TimeOut is a 1-cycle pulse.
  - The run restarts one cycle later, giving a repeat period of P*CLK_DIV + 2 cycles.
- Rst asserted at any time forces all reset values immediately, independent of Clk, including mid-RUN and in TIMEOUT. Period_Reg also returns to DEFAULT_TIMEOUT.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert Rst mid-cycle with Clk stopped. Required: Timer_TimeOut=0, Timer_Busy=0 and Timer_Count=0 immediately. Then enable with defaults (CLK_DIV=4, P=10): Timer_TimeOut rises 40 edges after the enable edge.
- Basic run: in IDLE, load Load_Value=3, then raise Timer_Enable. Required: Timer_Count reads 3, 2, 1, 0 with a change every 4 cycles; Timer_TimeOut=1 after edge E+12; Timer_TimeOut holds while Timer_Enable=1 and clears one edge after Timer_Enable drops.
- Abort: with P=5, drop Timer_Enable after 7 cycles. Required: IDLE next edge, Timer_Count=0, Timer_TimeOut never asserted. Re-enabling restarts the full 20-cycle run.
- Load rules:
  - Load_Value=0 in IDLE gives a 1-tick run (TimeOut at E+4).
  - Load_Enable=1 with value 9 during RUN does not change the current run or the next one.
  - Simultaneous Load 2 and enable in IDLE gives TimeOut at E+8.
- Closed loop: emulate the controller with Config_Enable=1 and P=2, CLK_DIV=1. Required: Timer_TimeOut pulses one cycle high every 4 cycles.
- Reset mid-run: assert Rst while Timer_Count=2. Required: outputs cleared asynchronously and Period_Reg back to DEFAULT_TIMEOUT, confirmed by the next run's timeout at E+40.

Source files
------------

// File: rtl/timeout_timer_if.sv
// Signal bundle between the timer controller (master) and the timeout timer (slave).
// Carries the run request, period load port and timer status outputs.
interface timeout_timer_if #(
   parameter int CNT_WIDTH = 8
);
   logic                 Timer_Enable;
   logic                 Load_Enable;
   logic [CNT_WIDTH-1:0] Load_Value;
   logic                 Timer_TimeOut;
   logic [CNT_WIDTH-1:0] Timer_Count;
   logic                 Timer_Busy;

   modport master (
      output Timer_Enable, Load_Enable, Load_Value,
      input  Timer_TimeOut, Timer_Count, Timer_Busy
   );

   modport slave (
      input  Timer_Enable, Load_Enable, Load_Value,
      output Timer_TimeOut, Timer_Count, Timer_Busy
   );
endinterface

// File: rtl/timeout_timer.sv
// Programmable down-counting timeout timer: counts Period_Reg prescaled ticks
// while enabled, then holds Timer_TimeOut until the enable is withdrawn.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | stopped; period may be loaded; enable starts a run
// ST_RUN     | counting ticks down; enable low aborts without timeout
// ST_TIMEOUT | period expired; Timer_TimeOut held until enable drops
module timeout_timer #(
   parameter int CLK_DIV         = 4,
   parameter int CNT_WIDTH       = 8,
   parameter int DEFAULT_TIMEOUT = 10
) (
   input logic            Clk,
   input logic            Rst,
   timeout_timer_if.slave bus
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]        PRESC_MAX  = PW'(CLK_DIV - 1);
   localparam logic [CNT_WIDTH-1:0] DEF_PERIOD = CNT_WIDTH'(DEFAULT_TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_t;

   state_t               state_q,   state_d;
   logic [CNT_WIDTH-1:0] period_q,  period_d;
   logic [PW-1:0]        presc_q,   presc_d;
   logic [CNT_WIDTH-1:0] count_q,   count_d;
   logic                 timeout_q, timeout_d;
   logic                 busy_q,    busy_d;
   logic [CNT_WIDTH-1:0] load_clamped;

   // A zero period would never expire, so it is treated as one tick.
   assign load_clamped = (bus.Load_Value == '0) ? CNT_ONE : bus.Load_Value;

   always_comb begin
      state_d   = state_q;
      period_d  = period_q;
      presc_d   = presc_q;
      count_d   = count_q;
      timeout_d = timeout_q;
      busy_d    = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.Load_Enable) begin
               period_d = load_clamped;
            end
            if (bus.Timer_Enable) begin
               state_d = ST_RUN;
               presc_d = '0;
               count_d = bus.Load_Enable ? load_clamped : period_q;
               busy_d  = 1'b1;
            end
         end

         ST_RUN: begin
            if (!bus.Timer_Enable) begin
               state_d = ST_IDLE;
               presc_d = '0;
               count_d = '0;
               busy_d  = 1'b0;
            end else if (presc_q == PRESC_MAX) begin
               presc_d = '0;
               if (count_q <= CNT_ONE) begin
                  state_d   = ST_TIMEOUT;
                  count_d   = '0;
                  timeout_d = 1'b1;
                  busy_d    = 1'b0;
               end else begin
                  count_d = count_q - CNT_ONE;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end

         ST_TIMEOUT: begin
            if (!bus.Timer_Enable) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b0;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            presc_d   = '0;
            count_d   = '0;
            timeout_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= ST_IDLE;
         period_q  <= DEF_PERIOD;
         presc_q   <= '0;
         count_q   <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         presc_q   <= presc_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.Timer_TimeOut = timeout_q;
   assign bus.Timer_Count   = count_q;
   assign bus.Timer_Busy    = busy_q;

endmodule

// File: tb/tb_timeout_timer.sv
// Directed bench for timeout_timer: default instance (CLK_DIV=4, P=10) plus a
// CLK_DIV=1 instance run in closed loop with an emulated controller.
module tb_timeout_timer;

   logic clk;
   logic clk_run;
   logic rst;
   logic cfg_en;
   int   n_cmp;
   int   n_err;
   int   k;
   logic seen_to;

   timeout_timer_if #(.CNT_WIDTH(8)) bus_a ();
   timeout_timer_if #(.CNT_WIDTH(8)) bus_b ();

   timeout_timer #(.CLK_DIV(4), .CNT_WIDTH(8), .DEFAULT_TIMEOUT(10)) u_a (
      .Clk (clk),
      .Rst (rst),
      .bus (bus_a)
   );

   timeout_timer #(.CLK_DIV(1), .CNT_WIDTH(8), .DEFAULT_TIMEOUT(10)) u_b (
      .Clk (clk),
      .Rst (rst),
      .bus (bus_b)
   );

   assign bus_b.Timer_Enable = cfg_en & ~bus_b.Timer_TimeOut;

   always #5 clk = clk_run ? ~clk : clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts edges after E until Timer_TimeOut is seen, bounded by max_edges.
   task automatic wait_to(input int max_edges, output int edges);
      edges = 0;
      do begin
         step();
         edges++;
      end while (bus_a.Timer_TimeOut !== 1'b1 && edges < max_edges);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0; clk_run = 1'b0; rst = 1'b0; cfg_en = 1'b0;
      n_cmp = 0; n_err = 0; seen_to = 1'b0;
      bus_a.Timer_Enable = 1'b0; bus_a.Load_Enable = 1'b0; bus_a.Load_Value = '0;
      bus_b.Load_Enable = 1'b0; bus_b.Load_Value = '0;

      // Reset with the clock stopped
      #3 rst = 1'b1;
      #1;
      check("rst_timeout", bus_a.Timer_TimeOut, 0);
      check("rst_busy",    bus_a.Timer_Busy,    0);
      check("rst_count",   bus_a.Timer_Count,   0);
      #1 rst = 1'b0;
      clk_run = 1'b1;
      step(); step();

      // Default period run
      bus_a.Timer_Enable = 1'b1;
      step();
      check("def_busy_after_E",  bus_a.Timer_Busy,  1);
      check("def_count_after_E", bus_a.Timer_Count, 10);
      wait_to(200, k);
      check("def_timeout_edges", k, 40);
      check("def_busy_at_to",    bus_a.Timer_Busy,  0);
      check("def_count_at_to",   bus_a.Timer_Count, 0);
      bus_a.Timer_Enable = 1'b0;
      step();
      check("def_to_clear", bus_a.Timer_TimeOut, 0);

      // Basic run with P=3
      bus_a.Load_Enable = 1'b1; bus_a.Load_Value = 8'd3;
      step();
      bus_a.Load_Enable = 1'b0;
      bus_a.Timer_Enable = 1'b1;
      step();
      check("p3_count_E",  bus_a.Timer_Count, 3);
      step(); step(); step();
      check("p3_count_E3", bus_a.Timer_Count, 3);
      step();
      check("p3_count_E4", bus_a.Timer_Count, 2);
      step(); step(); step(); step();
      check("p3_count_E8", bus_a.Timer_Count, 1);
      step(); step(); step();
      check("p3_to_low_E11", bus_a.Timer_TimeOut, 0);
      step();
      check("p3_count_E12", bus_a.Timer_Count,   0);
      check("p3_to_E12",    bus_a.Timer_TimeOut, 1);
      step(); step(); step();
      check("p3_to_hold",   bus_a.Timer_TimeOut, 1);
      bus_a.Timer_Enable = 1'b0;
      step();
      check("p3_to_clear",  bus_a.Timer_TimeOut, 0);

      // Abort with P=5 after 7 cycles
      bus_a.Load_Enable = 1'b1; bus_a.Load_Value = 8'd5;
      step();
      bus_a.Load_Enable = 1'b0;
      bus_a.Timer_Enable = 1'b1;
      step();
      seen_to = bus_a.Timer_TimeOut;
      for (int i = 0; i < 7; i++) begin
         step();
         seen_to = seen_to | bus_a.Timer_TimeOut;
      end
      bus_a.Timer_Enable = 1'b0;
      step();
      seen_to = seen_to | bus_a.Timer_TimeOut;
      check("abort_busy",    bus_a.Timer_Busy,  0);
      check("abort_count",   bus_a.Timer_Count, 0);
      check("abort_no_to",   seen_to,           0);
      bus_a.Timer_Enable = 1'b1;
      step();
      check("abort_restart_count", bus_a.Timer_Count, 5);
      wait_to(200, k);
      check("abort_restart_edges", k, 20);
      bus_a.Timer_Enable = 1'b0;
      step();

      // Load 0 clamps to one tick
      bus_a.Load_Enable = 1'b1; bus_a.Load_Value = 8'd0;
      step();
      bus_a.Load_Enable = 1'b0;
      bus_a.Timer_Enable = 1'b1;
      step();
      check("zero_count_E", bus_a.Timer_Count, 1);
      wait_to(200, k);
      check("zero_edges", k, 4);
      bus_a.Timer_Enable = 1'b0;
      step();

      // Load during RUN is ignored, for this run and the next
      bus_a.Timer_Enable = 1'b1;
      step();
      bus_a.Load_Enable = 1'b1; bus_a.Load_Value = 8'd9;
      wait_to(200, k);
      check("runload_edges", k, 4);
      bus_a.Load_Enable = 1'b0;
      bus_a.Timer_Enable = 1'b0;
      step();
      bus_a.Timer_Enable = 1'b1;
      step();
      check("runload_next_count", bus_a.Timer_Count, 1);
      wait_to(200, k);
      check("runload_next_edges", k, 4);
      bus_a.Timer_Enable = 1'b0;
      step();

      // Simultaneous load and enable
      bus_a.Load_Enable = 1'b1; bus_a.Load_Value = 8'd2;
      bus_a.Timer_Enable = 1'b1;
      step();
      bus_a.Load_Enable = 1'b0;
      check("simul_count_E", bus_a.Timer_Count, 2);
      wait_to(200, k);
      check("simul_edges", k, 8);
      bus_a.Timer_Enable = 1'b0;
      step();

      // Closed loop on the CLK_DIV=1 instance, P=2
      bus_b.Load_Enable = 1'b1; bus_b.Load_Value = 8'd2;
      step();
      bus_b.Load_Enable = 1'b0;
      cfg_en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         check($sformatf("loop_to_%0d", i), bus_b.Timer_TimeOut, ((i % 4) == 3) ? 1 : 0);
      end
      cfg_en = 1'b0;
      step(); step();

      // Reset mid-run restores the default period
      bus_a.Load_Enable = 1'b1; bus_a.Load_Value = 8'd3;
      step();
      bus_a.Load_Enable = 1'b0;
      bus_a.Timer_Enable = 1'b1;
      step();
      step(); step(); step(); step();
      check("midrst_count_pre", bus_a.Timer_Count, 2);
      #2 rst = 1'b1;
      #1;
      check("midrst_count",   bus_a.Timer_Count,   0);
      check("midrst_busy",    bus_a.Timer_Busy,    0);
      check("midrst_timeout", bus_a.Timer_TimeOut, 0);
      bus_a.Timer_Enable = 1'b0;
      #1 rst = 1'b0;
      step();
      bus_a.Timer_Enable = 1'b1;
      step();
      check("midrst_next_count", bus_a.Timer_Count, 10);
      wait_to(200, k);
      check("midrst_next_edges", k, 40);
      bus_a.Timer_Enable = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
